// File: rtl/ram72x4_pkg.sv
// Shared widths, sweep depth and FSM state encoding for the 72x4 RAM controller.
package ram72x4_pkg;

  localparam int unsigned DATA_W = 72;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DEPTH  = 4;
  // One extra bit so the sweep counter can reach DEPTH and mark the end of init.
  localparam int unsigned CNT_W  = ADDR_W + 1;

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    IDLE     = 3'd1,
    RD_ISSUE = 3'd2,
    RD_CAPT  = 3'd3,
    RSP      = 3'd4
  } state_t;

endpackage

// File: rtl/ram72x4_ctrl.sv
// Initiator for the 72x4 DFF RAM: init sweep after reset, then valid/ready
// requests mapped onto active-low RAM strobes with a single-outstanding read.
module ram72x4_ctrl
  import ram72x4_pkg::*;
#(
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic              ram_en_n,
  output logic              ram_wr_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             req_hs_c;

  assign req_hs_c = req_valid && req_ready;

  // Strobes default to idle every cycle so each RAM access lasts exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      init_done <= 1'b0;
      ram_en_n  <= 1'b1;
      ram_wr_n  <= 1'b1;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_en_n <= 1'b1;
      ram_wr_n <= 1'b1;
      case (state)
        INIT: begin
          if (cnt == CNT_W'(DEPTH)) begin
            state     <= IDLE;
            init_done <= 1'b1;
            req_ready <= 1'b1;
          end else begin
            ram_en_n  <= 1'b0;
            ram_wr_n  <= 1'b0;
            ram_addr  <= cnt[ADDR_W-1:0];
            ram_wdata <= INIT_VALUE;
            cnt       <= cnt + CNT_W'(1);
          end
        end
        IDLE: begin
          if (req_hs_c) begin
            ram_en_n <= 1'b0;
            ram_wr_n <= ~req_we;
            ram_addr <= req_addr;
            if (req_we) begin
              ram_wdata <= req_wdata;
            end else begin
              req_ready <= 1'b0;
              state     <= RD_ISSUE;
            end
          end
        end
        // RAM latches read data on this edge; capture happens one edge later.
        RD_ISSUE: state <= RD_CAPT;
        RD_CAPT: begin
          rsp_rdata <= ram_rdata;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ram72x4_ctrl.sv
// Self-checking bench for ram72x4_ctrl: directed table, stall and reset
// sequences, then random traffic against a transaction-level reference model.
module tb_ram72x4_ctrl;
  import ram72x4_pkg::*;

  localparam logic [DATA_W-1:0] INIT_VAL = '0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic              init_done;
  logic              ram_en_n;
  logic              ram_wr_n;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  always #5 clk = ~clk;

  ram72x4_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .ram_en_n(ram_en_n), .ram_wr_n(ram_wr_n), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Behavioural 72x4 RAM with active-low strobes and registered read.
  logic [DATA_W-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (!ram_en_n) begin
      if (!ram_wr_n) ram_mem[ram_addr] <= ram_wdata;
      else           ram_rdata <= ram_mem[ram_addr];
    end
  end

  // Reference model: memory contents plus request/response bookkeeping.
  int                unsigned init_e;
  bit                m_ready, m_rsp_valid, m_done;
  int                m_wait;
  logic [DATA_W-1:0] m_rsp_data, m_pend;
  logic [DATA_W-1:0] mem_m [DEPTH];
  bit                e_en_n, e_wr_n;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata;
  bit                hs_seen;
  int                n_checks = 0;
  int                n_err = 0;

  typedef struct {
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp;
  } vec_t;
  vec_t tbl [14];

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    init_e = 0; m_ready = 0; m_rsp_valid = 0; m_done = 0; m_wait = 0;
    m_rsp_data = '0; m_pend = '0;
    e_en_n = 1; e_wr_n = 1; e_addr = '0; e_wdata = '0;
    for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = INIT_VAL;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_update();
    hs_seen = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_en_n = 1; e_wr_n = 1;
    if (init_e < DEPTH) begin
      e_en_n = 0; e_wr_n = 0; e_addr = ADDR_W'(init_e); e_wdata = INIT_VAL;
      init_e++;
    end else if (init_e == DEPTH) begin
      init_e++; m_ready = 1; m_done = 1;
    end else if (m_ready && req_valid) begin
      hs_seen = 1; e_en_n = 0; e_addr = req_addr;
      if (req_we) begin
        e_wr_n = 0; e_wdata = req_wdata; mem_m[req_addr] = req_wdata;
      end else begin
        m_ready = 0; m_pend = mem_m[req_addr]; m_wait = 2;
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_rsp_valid = 1; m_rsp_data = m_pend;
      end
    end else if (m_rsp_valid && rsp_ready) begin
      m_rsp_valid = 0; m_ready = 1;
    end
  endtask

  task automatic check_all();
    check("req_ready", DATA_W'(req_ready), DATA_W'(m_ready));
    check("rsp_valid", DATA_W'(rsp_valid), DATA_W'(m_rsp_valid));
    check("init_done", DATA_W'(init_done), DATA_W'(m_done));
    check("ram_en_n", DATA_W'(ram_en_n), DATA_W'(e_en_n));
    check("ram_wr_n", DATA_W'(ram_wr_n), DATA_W'(e_wr_n));
    check("rsp_rdata", rsp_rdata, m_rsp_data);
    if (!e_en_n) check("ram_addr", DATA_W'(ram_addr), DATA_W'(e_addr));
    if (!e_en_n && !e_wr_n) check("ram_wdata", ram_wdata, e_wdata);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  // Present one request, wait for its handshake, and for reads wait for rsp_valid.
  task automatic do_req(input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input bit rr,
                        output int hs_ticks, output int lat,
                        output logic [DATA_W-1:0] data);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; rsp_ready = rr;
    hs_ticks = 0; lat = 0; data = '0;
    do begin
      tick(); hs_ticks++;
    end while (!hs_seen && hs_ticks < 20);
    if (!hs_seen) check("req_handshake_timeout", 0, 1);
    req_valid = 0;
    if (!we && hs_seen) begin
      while (!rsp_valid && lat < 10) begin
        tick(); lat++;
      end
      if (!rsp_valid) check("rsp_timeout", 0, 1);
      data = rsp_rdata;
    end
  endtask

  task automatic run_vec(input int i);
    int hs_ticks, lat;
    logic [DATA_W-1:0] d;
    do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b1, hs_ticks, lat, d);
    check($sformatf("vec%0d_hs_ticks", i), DATA_W'(hs_ticks), DATA_W'(1));
    if (!tbl[i].we) begin
      check($sformatf("vec%0d_rdata", i), d, tbl[i].exp);
      check($sformatf("vec%0d_latency", i), DATA_W'(lat), DATA_W'(2));
      tick();
    end
  endtask

  initial begin
    int hs_ticks, lat;
    logic [DATA_W-1:0] d;

    for (int i = 0; i < 4; i++) tbl[i] = '{0, ADDR_W'(i), '0, INIT_VAL};
    tbl[4] = '{1, 2'd2, 72'hA5A5_0000_1234_5678_9A, '0};
    tbl[5] = '{0, 2'd2, '0, 72'hA5A5_0000_1234_5678_9A};
    for (int i = 0; i < 4; i++) tbl[6+i]  = '{1, ADDR_W'(i), DATA_W'(i+1), '0};
    for (int i = 0; i < 4; i++) tbl[10+i] = '{0, ADDR_W'(i), '0, DATA_W'(i+1)};

    // Reset, with a write request held pending through the whole init sweep.
    model_reset();
    tick(); tick();
    req_valid = 1; req_we = 1; req_addr = 2'd1; req_wdata = '1;
    rsp_ready = 1;
    rst_n = 1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check($sformatf("init_done_edge%0d", e), DATA_W'(init_done), DATA_W'(e == 5));
      check($sformatf("no_hs_edge%0d", e), DATA_W'(hs_seen), DATA_W'(0));
    end
    req_valid = 0;
    tick();

    for (int i = 0; i < 14; i++) run_vec(i);

    // Response stalled by rsp_ready=0 for six cycles.
    do_req(0, 2'd3, '0, 1'b0, hs_ticks, lat, d);
    check("stall_rdata", d, DATA_W'(4));
    for (int c = 0; c < 6; c++) begin
      tick();
      check("stall_valid", DATA_W'(rsp_valid), DATA_W'(1));
      check("stall_hold", rsp_rdata, d);
      check("stall_ready", DATA_W'(req_ready), DATA_W'(0));
    end
    rsp_ready = 1;
    tick();
    check("stall_release_valid", DATA_W'(rsp_valid), DATA_W'(0));
    check("stall_release_ready", DATA_W'(req_ready), DATA_W'(1));

    // Reset asserted while the controller sits in RD_CAPT.
    req_valid = 1; req_we = 0; req_addr = 2'd2; rsp_ready = 1;
    tick();
    check("capt_hs", DATA_W'(hs_seen), DATA_W'(1));
    req_valid = 0;
    tick();
    rst_n = 0;
    #1;
    check("rst_ram_en_n", DATA_W'(ram_en_n), DATA_W'(1));
    check("rst_ram_wr_n", DATA_W'(ram_wr_n), DATA_W'(1));
    check("rst_ram_addr", DATA_W'(ram_addr), '0);
    check("rst_ram_wdata", ram_wdata, '0);
    check("rst_req_ready", DATA_W'(req_ready), '0);
    check("rst_rsp_valid", DATA_W'(rsp_valid), '0);
    check("rst_rsp_rdata", rsp_rdata, '0);
    check("rst_init_done", DATA_W'(init_done), '0);
    model_reset();
    tick(); tick();
    rst_n = 1;
    for (int e = 0; e < 6; e++) tick();
    for (int i = 0; i < 4; i++) run_vec(i);

    // Random traffic against the reference model.
    for (int c = 0; c < 500; c++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
      req_wdata = DATA_W'({$urandom, $urandom, $urandom});
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ram72x4_ctrl.md
# ram72x4_ctrl

Initiator-side controller for the team's 72x4 DFF RAM, which has an active-low enable, an active-low write, and a registered read. It converts a valid/ready request stream from the datapath into the RAM's enable/write/address/data pin protocol and returns read data on a valid/ready response channel. After every reset it runs a 4-cycle initialization sweep that writes INIT_VALUE to all entries, so the datapath never reads uninitialized storage.

## Interface
- DATA_W, 72, data width; matches the RAM word.
- ADDR_W, 2, address width.
- DEPTH, 4, number of entries swept during init.
- INIT_VALUE, 72'h0, word written to every entry during init.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts the request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target entry.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_W  read data, held stable while rsp_valid=1.
- init_done  out  1  init sweep finished; stays high until the next reset.
- ram_en_n  out  1  RAM enable, active-low, registered.
- ram_wr_n  out  1  RAM write, active-low, registered.
- ram_addr  out  ADDR_W  RAM address, registered.
- ram_wdata  out  DATA_W  RAM write data, registered.
- ram_rdata  in  DATA_W  RAM registered read data.

## Operation
- Reset values: ram_en_n=1, ram_wr_n=1, ram_addr=0, ram_wdata=0, req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0. FSM state is INIT with the sweep counter at 0.
- INIT:
  - Drives ram_en_n=0, ram_wr_n=0, ram_addr=cnt, ram_wdata=INIT_VALUE for cnt = 0..DEPTH-1.
  - After the last write goes to IDLE and sets init_done=1.
  - req_ready=0 throughout, so requests arriving during init are not accepted.
- IDLE:
  - req_ready=1.
  - A write handshake drives a one-cycle RAM write. The controller stays in IDLE, so back-to-back writes run at 1 per cycle.
  - A read handshake drives a one-cycle RAM read and moves to RD_ISSUE.
  - With no handshake, ram_en_n=1 and ram_wr_n=1.
- RD_ISSUE: req_ready=0, RAM strobes are deasserted, and the FSM moves to RD_CAPT.
- RD_CAPT: captures ram_rdata into rsp_rdata, sets rsp_valid=1, and moves to RSP.
- RSP:
  - req_ready=0.
  - Holds rsp_valid and rsp_rdata until rsp_ready=1.
  - On the response handshake, clears rsp_valid and returns to IDLE.
- Only one read is outstanding at a time. Writes never generate a response.
- A write immediately followed by a read of the same address returns the new data, because RAM strobes are issued in request order.

## Timing
- Init: the writes to addresses 0..3 are driven in the 4 cycles after the first clock edge with rst_n=1. init_done and req_ready go high after the 5th edge.
- Write: accepted at edge k; strobes are low during cycle k→k+1; the RAM commits at edge k+1.
- Read: accepted at edge k; strobes are low during cycle k→k+1; ram_rdata is valid after edge k+1; rsp_valid=1 after edge k+2. The minimum read-to-next-request gap is 3 cycles plus the rsp_ready stall.
- rsp_ready=1 in the first rsp_valid cycle completes the handshake at that edge; req_ready is high in the following cycle.
- rsp_ready held 0 stalls indefinitely with rsp_rdata stable.
- Reset asserted mid-read or mid-init:
  - Immediately forces all outputs to their reset values and drops any pending response.
  - After release the init sweep reruns from address 0.
- req_addr, req_we, and req_wdata are sampled only on the handshake edge.

## Structure
- Shared package ram72x4_pkg holds DATA_W, ADDR_W, DEPTH, and the FSM state enum (INIT, IDLE, RD_ISSUE, RD_CAPT, RSP).
- Single module with no sub-module. The RAM macro is instantiated alongside it by the parent and by the bench.

## Test plan
- Reset release, then read addresses 0..3 → each returns 72'h0; init_done rises exactly 5 edges after release.
- Write 72'hA5A5_0000_1234_5678_9A to address 2, then read address 2 → rsp_rdata matches, with rsp_valid 2 edges after the read handshake.
- Back-to-back writes to addresses 0,1,2,3 with data 72'h1, 72'h2, 72'h3, 72'h4 → req_ready stays 1 for all 4 cycles; subsequent reads return 1, 2, 3, 4.
- Read with rsp_ready held 0 for 6 cycles → rsp_valid and rsp_rdata stay stable and req_ready stays 0; the response completes on the first rsp_ready=1 cycle.
- req_valid=1 during init → no handshake occurs and the RAM sees only the init writes.
- Assert rst_n=0 in RD_CAPT → all outputs return to reset values within the same cycle, no response is emitted, and init reruns after release.
